// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   state_t  - controller FSM states
//   owner_t  - which requester currently owns the memory bus
//   MODE_WORD - data-memory access mode for a full 32-bit word (LW/SW funct3)
//   CNT_W    - width of the instruction-fetch starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [2:0] MODE_WORD = 3'b010;
  localparam int         CNT_W     = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant select between fetch (I) and load/store (D).
//   D has priority unless I has already lost MAX_IWAIT arbitrations in a row.
// Ports:
//   i_req, d_req  - pending requests
//   cnt           - current starvation count
//   grant         - some requester wins this arbitration
//   owner         - the winner (only meaningful with grant)
//   cnt_next      - starvation count to store if the grant is taken
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_IWAIT = 4
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] cnt,
  output logic             grant,
  output owner_t           owner,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_IWAIT);

  logic starved;

  always_comb begin
    starved  = (cnt == MAX_C);
    grant    = i_req | d_req;
    owner    = (d_req && !(i_req && starved)) ? OWN_D : OWN_I;
    cnt_next = cnt;
    if (owner == OWN_I)
      cnt_next = '0;
    else if (i_req && !starved)
      cnt_next = cnt + CNT_W'(1);  // only counts losses I actually suffered
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between
// instruction fetch (I) and the memory-stage load/store path (D).
// Every access runs IDLE -> BUSY_x -> DONE -> IDLE; the DONE cycle carries the
// one-cycle ack and never arbitrates, so a request still visible alongside its
// own ack is not serviced twice.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack   - fetch request / response
//   d_req/d_we/d_mode/d_addr/d_wdata -> d_rdata/d_ack - load/store request / response
//   mem_req/we/mode/addr/wdata      - registered memory command, held until mem_ready
//   mem_ready/mem_rdata             - memory completion and read data
// Optional: define MEM_PORT_ARBITER_STATS_EN to add stat_i_grants,
//   stat_d_grants and stat_conflicts (wrapping WIDTH-bit counters).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_IWAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_mode,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_mode,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [WIDTH-1:0] stat_i_grants,
  output logic [WIDTH-1:0] stat_d_grants,
  output logic [WIDTH-1:0] stat_conflicts
`endif
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mem_req_n, mem_we_n, i_ack_n, d_ack_n;
  logic [2:0]       mem_mode_n;
  logic [WIDTH-1:0] mem_addr_n, mem_wdata_n, i_rdata_n, d_rdata_n;

  logic             grant;
  owner_t           owner;
  logic [CNT_W-1:0] cnt_pick;

  mem_arb_pick #(.MAX_IWAIT(MAX_IWAIT)) u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .cnt      (cnt),
    .grant    (grant),
    .owner    (owner),
    .cnt_next (cnt_pick)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_mode_n  = mem_mode;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    i_ack_n     = 1'b0;
    d_ack_n     = 1'b0;
    unique case (state)
      IDLE: if (grant) begin
        mem_req_n = 1'b1;
        cnt_n     = cnt_pick;
        if (owner == OWN_D) begin
          state_n     = BUSY_D;
          mem_we_n    = d_we;
          mem_mode_n  = d_mode;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
        end else begin
          state_n    = BUSY_I;
          mem_we_n   = 1'b0;
          mem_mode_n = MODE_WORD;
          mem_addr_n = i_addr;
        end
      end
      BUSY_I: if (mem_ready) begin
        state_n   = DONE;
        mem_req_n = 1'b0;
        i_rdata_n = mem_rdata;
        i_ack_n   = 1'b1;
      end
      BUSY_D: if (mem_ready) begin
        state_n   = DONE;
        mem_req_n = 1'b0;
        d_ack_n   = 1'b1;
        if (!mem_we) d_rdata_n = mem_rdata;  // stores leave load data untouched
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_mode  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_mode  <= mem_mode_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      i_rdata   <= i_rdata_n;
      d_rdata   <= d_rdata_n;
      i_ack     <= i_ack_n;
      d_ack     <= d_ack_n;
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else if (state == IDLE) begin
      if (grant && owner == OWN_I) stat_i_grants <= stat_i_grants + WIDTH'(1);
      if (grant && owner == OWN_D) stat_d_grants <= stat_d_grants + WIDTH'(1);
      if (i_req && d_req)          stat_conflicts <= stat_conflicts + WIDTH'(1);
    end
  end
`endif

  // Requesters must hold req and payload until their ack. Violations are
  // undefined behaviour (the FSM still always returns to IDLE), so flag them.
  a_i_hold: assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_I) |-> (i_req && i_addr == mem_addr));
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (state == BUSY_D) |-> (d_req && d_addr == mem_addr && d_we == mem_we &&
                           d_mode == mem_mode && d_wdata == mem_wdata));

endmodule
